// File: rtl/game_pkg.sv
// Shared constants and types for the game state controller: opcodes,
// FSM encoding, tile width and default score ceiling.
package game_pkg;

  localparam int unsigned TILE_W        = 3;
  localparam int unsigned SCORE_MAX_DEF = 999;

  localparam logic [7:0] OP_WRITE_CELL = 8'h01;
  localparam logic [7:0] OP_SET_SCORE  = 8'h02;
  localparam logic [7:0] OP_ADD_SCORE  = 8'h03;
  localparam logic [7:0] OP_CLEAR      = 8'h04;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_CLEAR
  } fsm_t;

  function automatic logic [9:0] sat_score(input logic [10:0] v, input logic [10:0] vmax);
    return (v > vmax) ? vmax[9:0] : v[9:0];
  endfunction

endpackage

// File: rtl/tile_ram.sv
// Tile store: one write port, one registered read port. Memory contents
// survive reset; only the read register is cleared.
module tile_ram
  import game_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [TILE_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic              i_rd_zero,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [TILE_W-1:0] o_rdata
);

  logic [TILE_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [TILE_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Same-edge read of a written address returns the old word (read-first).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= i_rd_zero ? '0 : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/game_state_ctrl.sv
// Game state controller: decodes SPI frames (end-of-frame on synchronized cs
// falling edge) into tile writes, score updates and a full-memory clear sweep.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int SCORE_MAX = SCORE_MAX_DEF
) (
  input  logic              clk,
  input  logic              resetB,
  input  logic              cs,
  input  logic [7:0]        command,
  input  logic [7:0]        databyte1,
  input  logic [7:0]        databyte2,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       state,
  output logic [9:0]        score,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [10:0] SMAX = 11'(SCORE_MAX);

  fsm_t              r_fsm, w_fsm_nxt;
  logic              r_cs_s1, r_cs_s2, r_cs_s3;
  logic [7:0]        r_cmd, r_db2;
  logic [4:0]        r_db1;
  logic [9:0]        r_score, w_score_nxt;
  logic              r_err, w_err_set;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              w_eof;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [TILE_W-1:0] w_wdata;
  logic [TILE_W-1:0] w_rdata;
  logic              w_unused_db1;

  assign w_unused_db1 = &{1'b0, databyte1[7:5]};

  always_ff @(posedge clk) begin
    if (!resetB) begin
      r_cs_s1 <= 1'b0;
      r_cs_s2 <= 1'b0;
      r_cs_s3 <= 1'b0;
    end else begin
      r_cs_s1 <= cs;
      r_cs_s2 <= r_cs_s1;
      r_cs_s3 <= r_cs_s2;
    end
  end

  assign w_eof = r_cs_s3 & ~r_cs_s2;

  always_ff @(posedge clk) begin
    if (!resetB) r_fsm <= ST_IDLE;
    else         r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_we        = 1'b0;
    w_waddr     = r_clr_addr;
    w_wdata     = '0;
    w_score_nxt = r_score;
    w_err_set   = w_eof && (r_fsm == ST_CLEAR);
    case (r_fsm)
      ST_IDLE: if (w_eof) w_fsm_nxt = ST_DECODE;
      ST_DECODE: begin
        w_fsm_nxt = ST_EXEC;
        case (r_cmd)
          OP_WRITE_CELL: begin
            w_we    = 1'b1;
            w_waddr = ADDR_W'({r_db1[1:0], r_db2});
            w_wdata = r_db1[4:2];
          end
          OP_SET_SCORE: w_score_nxt = sat_score({1'b0, r_db1[1:0], r_db2}, SMAX);
          OP_ADD_SCORE: w_score_nxt = sat_score({1'b0, r_score} + {3'b000, r_db2}, SMAX);
          OP_CLEAR:     w_fsm_nxt   = ST_CLEAR;
          default:      w_err_set   = 1'b1;
        endcase
      end
      ST_EXEC: w_fsm_nxt = ST_IDLE;
      ST_CLEAR: begin
        w_we = 1'b1;
        if (r_clr_addr == '1) w_fsm_nxt = ST_IDLE;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetB) begin
      r_cmd      <= '0;
      r_db1      <= '0;
      r_db2      <= '0;
      r_score    <= '0;
      r_err      <= 1'b0;
      r_clr_addr <= '0;
    end else begin
      if (r_fsm == ST_IDLE && w_eof) begin
        r_cmd <= command;
        r_db1 <= databyte1[4:0];
        r_db2 <= databyte2;
      end
      r_score <= w_score_nxt;
      if (w_err_set) r_err <= 1'b1;
      if (r_fsm == ST_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
      else                   r_clr_addr <= '0;
    end
  end

  // Write strobe gated by reset so an interrupted sweep leaves the current cell intact.
  tile_ram #(.ADDR_W(ADDR_W)) u_tile_ram (
    .i_clk     (clk),
    .i_rst_n   (resetB),
    .i_we      (w_we & resetB),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_re      (re),
    .i_rd_zero (busy),
    .i_raddr   (raddr),
    .o_rdata   (w_rdata)
  );

  assign state   = {{(16-TILE_W){1'b0}}, w_rdata};
  assign score   = r_score;
  assign busy    = (r_fsm == ST_CLEAR);
  assign cmd_err = r_err;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with a read-data scoreboard queue.
module tb_game_state_ctrl;

  logic        clk = 1'b0;
  logic        resetB;
  logic        cs;
  logic [7:0]  command, databyte1, databyte2;
  logic        re;
  logic [9:0]  raddr;
  logic [15:0] state;
  logic [9:0]  score;
  logic        busy;
  logic        cmd_err;

  int n_cmp = 0;
  int n_mis = 0;
  int busy_cnt = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  game_state_ctrl #(.ADDR_W(10), .SCORE_MAX(999)) dut (
    .clk       (clk),
    .resetB    (resetB),
    .cs        (cs),
    .command   (command),
    .databyte1 (databyte1),
    .databyte2 (databyte2),
    .re        (re),
    .raddr     (raddr),
    .state     (state),
    .score     (score),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [15:0] exp;
    if (sb.size() == 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      check(tag, state, exp);
    end
  endtask

  task automatic rd(input logic [9:0] a, input logic [15:0] exp, input string tag);
    re    = 1'b1;
    raddr = a;
    sb.push_back(exp);
    tick();
    re = 1'b0;
    pop_chk(tag);
  endtask

  // Full frame: cs high 3 cycles, low; effect visible after 4th edge; optional read on that edge.
  task automatic frame(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2,
                       input bit rd_en, input logic [9:0] ra, input logic [15:0] rexp);
    command   = c;
    databyte1 = b1;
    databyte2 = b2;
    cs = 1'b1;
    repeat (3) tick();
    cs = 1'b0;
    repeat (3) tick();
    if (rd_en) begin
      re    = 1'b1;
      raddr = ra;
      sb.push_back(rexp);
    end
    tick();
    if (rd_en) begin
      re = 1'b0;
      pop_chk("collision_read");
    end
    tick();
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 1200 && busy; g++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetB = 1'b0; cs = 1'b0; re = 1'b0; raddr = '0;
    command = '0; databyte1 = '0; databyte2 = '0;
    repeat (3) tick();
    check("rst_state", state, 16'h0);
    check("rst_score", {6'd0, score}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_err", {15'd0, cmd_err}, 16'd0);
    resetB = 1'b1;
    repeat (2) tick();

    frame(8'h04, 8'h00, 8'h00, 1'b0, '0, '0);
    wait_idle();
    check("init_clear_done", {15'd0, busy}, 16'd0);

    frame(8'h01, 8'h0D, 8'h05, 1'b0, '0, '0);
    rd(10'h105, 16'h0003, "write_cell_read");
    raddr = 10'h007;
    repeat (2) tick();
    check("read_hold", state, 16'h0003);

    frame(8'h02, 8'h03, 8'hE0, 1'b0, '0, '0);
    check("set_992", {6'd0, score}, 16'd992);
    frame(8'h03, 8'h00, 8'h14, 1'b0, '0, '0);
    check("add_sat", {6'd0, score}, 16'd999);
    frame(8'h02, 8'h00, 8'h05, 1'b0, '0, '0);
    check("set_5", {6'd0, score}, 16'd5);
    frame(8'h03, 8'h00, 8'h14, 1'b0, '0, '0);
    check("add_25", {6'd0, score}, 16'd25);
    frame(8'h02, 8'h03, 8'hFF, 1'b0, '0, '0);
    check("set_sat", {6'd0, score}, 16'd999);
    check("err_clean", {15'd0, cmd_err}, 16'd0);

    frame(8'h01, 8'h14, 8'h07, 1'b1, 10'h007, 16'h0000);
    rd(10'h007, 16'h0005, "collision_next");

    // Three frames with end-of-frame events exactly 3 cycles apart.
    frame(8'h02, 8'h00, 8'h00, 1'b0, '0, '0);
    command = 8'h03; databyte1 = 8'h00; databyte2 = 8'h01;
    for (int k = 0; k < 3; k++) begin
      cs = 1'b1; tick();
      cs = 1'b0; tick();
      tick();
    end
    repeat (6) tick();
    check("b2b_score", {6'd0, score}, 16'd3);

    frame(8'h7F, 8'h1D, 8'h05, 1'b0, '0, '0);
    check("badop_err", {15'd0, cmd_err}, 16'd1);
    check("badop_score", {6'd0, score}, 16'd3);
    rd(10'h105, 16'h0003, "badop_tile");

    frame(8'h01, 8'h1C, 8'h63, 1'b0, '0, '0);
    frame(8'h01, 8'h18, 8'h64, 1'b0, '0, '0);
    frame(8'h01, 8'h14, 8'h65, 1'b0, '0, '0);
    busy_cnt = 0;
    frame(8'h04, 8'h00, 8'h00, 1'b0, '0, '0);
    for (int g = 0; g < 1200 && busy_cnt < 101; g++) tick();
    resetB = 1'b0;
    cs = 1'b1; command = 8'h02; databyte1 = 8'h00; databyte2 = 8'h05;
    tick();
    check("rstmid_busy", {15'd0, busy}, 16'd0);
    check("rstmid_score", {6'd0, score}, 16'd0);
    check("rstmid_err", {15'd0, cmd_err}, 16'd0);
    check("rstmid_state", state, 16'h0);
    resetB = 1'b1;
    cs = 1'b0;
    repeat (8) tick();
    check("post_rst_frame_ignored", {6'd0, score}, 16'd0);
    check("post_rst_idle", {15'd0, busy}, 16'd0);
    rd(10'd99, 16'h0000, "rstmid_cell99");
    rd(10'd100, 16'h0006, "rstmid_cell100");
    rd(10'd101, 16'h0005, "rstmid_cell101");

    frame(8'h01, 8'h1C, 8'h00, 1'b0, '0, '0);
    frame(8'h01, 8'h0B, 8'hFF, 1'b0, '0, '0);
    rd(10'd0, 16'h0007, "cell0_pre");
    rd(10'd1023, 16'h0002, "cell1023_pre");
    busy_cnt = 0;
    frame(8'h04, 8'h00, 8'h00, 1'b0, '0, '0);
    for (int g = 0; g < 1200 && busy_cnt < 200; g++) tick();
    frame(8'h01, 8'h18, 8'h01, 1'b0, '0, '0);
    check("busy_frame_err", {15'd0, cmd_err}, 16'd1);
    check("busy_frame_busy", {15'd0, busy}, 16'd1);
    for (int g = 0; g < 1200 && busy_cnt < 600; g++) tick();
    rd(10'd1023, 16'h0000, "mid_sweep_read");
    wait_idle();
    check("busy_len", 16'(busy_cnt), 16'd1024);
    check("post_clear_score", {6'd0, score}, 16'd0);
    for (int a = 0; a < 1024; a++) rd(10'(a), 16'h0000, "cleared_cell");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
